// File: rtl/xnor_tile_driver.sv
`default_nettype none
// ============================================================================
// Module   : xnor_tile_driver
// Purpose  : Initiator/collector for one XNOR-popcount engine. For each
//            command it loads the engine weight register, streams pixel
//            vectors into the engine, and packs the returned 1-bit
//            activations LSB-first into OUT_WIDTH-bit output words.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset             : clock, synchronous active-high reset
//   cmd_valid/ready          : command handshake
//   cmd_weight, cmd_count    : weight vector and pixel count (0 is legal)
//   pix_valid/ready, pix_data: pixel vector stream
//   weight_wr, weight_in     : registered engine weight load
//   input_plugin, pixels_in  : registered engine pixel strobe/data
//   ready_in, result_in      : engine result (1 cycle after input_plugin)
//   out_valid/ready          : output word handshake
//   out_data, out_count      : packed activations, number of valid bits
//   out_last                 : final word of the command
//   busy                     : command in progress
//   err                      : sticky, result seen with nothing in flight
// ============================================================================
module xnor_tile_driver #(
    parameter int KERNEL_SIZE = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [KERNEL_SIZE-1:0]         cmd_weight,
    input  logic [CNT_WIDTH-1:0]           cmd_count,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [KERNEL_SIZE-1:0]         pix_data,
    output logic                           weight_wr,
    output logic [KERNEL_SIZE-1:0]         weight_in,
    output logic                           input_plugin,
    output logic [KERNEL_SIZE-1:0]         pixels_in,
    input  logic                           ready_in,
    input  logic                           result_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic [$clog2(OUT_WIDTH+1)-1:0] out_count,
    output logic                           out_last,
    output logic                           busy,
    output logic                           err
);

    localparam int FILL_W = $clog2(OUT_WIDTH + 1);
    localparam int IDX_W  = $clog2(OUT_WIDTH);
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W:0]   SUM_LIMIT = (FILL_W + 1)'(OUT_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_W = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     remaining_q, remaining_d;
    logic                     weight_wr_q, weight_wr_d;
    logic [KERNEL_SIZE-1:0]   weight_in_q, weight_in_d;
    logic                     input_plugin_q, input_plugin_d;
    logic [KERNEL_SIZE-1:0]   pixels_in_q, pixels_in_d;
    logic [FILL_W-1:0]        inflight_q, inflight_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [OUT_WIDTH-1:0]     pack_q, pack_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]     out_data_q, out_data_d;
    logic [FILL_W-1:0]        out_count_q, out_count_d;
    logic                     out_last_q, out_last_d;
    logic                     err_q, err_d;

    logic                     cmd_fire;
    logic                     pix_fire;
    logic                     capture;
    logic                     out_free;
    logic                     drain_done;
    logic                     emit;
    logic [FILL_W:0]          credit_sum;
    logic [FILL_W-1:0]        fill_base;
    logic [OUT_WIDTH-1:0]     pack_base;

    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        // Slots already committed to the current word: captured bits plus
        // results still in the engine pipeline.
        credit_sum = {1'b0, fill_q} + {1'b0, inflight_q};
        pix_ready  = (state_q == S_STREAM) && (remaining_q != '0) &&
                     (credit_sum < SUM_LIMIT);

        cmd_fire   = cmd_valid && cmd_ready;
        pix_fire   = pix_valid && pix_ready;
        capture    = ready_in && (inflight_q != '0);
        out_free   = !out_valid_q || out_ready;
        // Last word of a command: everything returned and something packed.
        // A full word at this point is the final word too (exact multiple).
        drain_done = (state_q == S_DRAIN) && (inflight_q == '0) && (fill_q != '0);
        emit       = out_free && ((fill_q == FULL_FILL) || drain_done);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                state_d = (remaining_q != '0) ? S_STREAM : S_IDLE;
            end
            S_STREAM: begin
                if (pix_fire && (remaining_q == CNT_WIDTH'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((inflight_q == '0) && ((fill_q == '0) || emit)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        weight_wr_d    = cmd_fire;
        weight_in_d    = cmd_fire ? cmd_weight : weight_in_q;
        input_plugin_d = pix_fire;
        pixels_in_d    = pix_fire ? pix_data : pixels_in_q;

        remaining_d = remaining_q;
        if (cmd_fire) begin
            remaining_d = cmd_count;
        end else if (pix_fire) begin
            remaining_d = remaining_q - CNT_WIDTH'(1);
        end

        inflight_d = inflight_q;
        if (pix_fire && !capture) begin
            inflight_d = inflight_q + FILL_W'(1);
        end else if (!pix_fire && capture) begin
            inflight_d = inflight_q - FILL_W'(1);
        end

        // On hand-off the packer restarts, so a result captured in the same
        // cycle becomes bit 0 of the next word.
        fill_base = emit ? '0 : fill_q;
        pack_base = emit ? '0 : pack_q;
        fill_d    = fill_base;
        pack_d    = pack_base;
        if (capture) begin
            pack_d[fill_base[IDX_W-1:0]] = result_in;
            fill_d                       = fill_base + FILL_W'(1);
        end

        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = pack_q;
            out_count_d = fill_q;
            out_last_d  = drain_done;
        end

        err_d = err_q || (ready_in && (inflight_q == '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            remaining_q    <= '0;
            weight_wr_q    <= 1'b0;
            weight_in_q    <= '0;
            input_plugin_q <= 1'b0;
            pixels_in_q    <= '0;
            inflight_q     <= '0;
            fill_q         <= '0;
            pack_q         <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_count_q    <= '0;
            out_last_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            weight_wr_q    <= weight_wr_d;
            weight_in_q    <= weight_in_d;
            input_plugin_q <= input_plugin_d;
            pixels_in_q    <= pixels_in_d;
            inflight_q     <= inflight_d;
            fill_q         <= fill_d;
            pack_q         <= pack_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_count_q    <= out_count_d;
            out_last_q     <= out_last_d;
            err_q          <= err_d;
        end
    end

    assign weight_wr    = weight_wr_q;
    assign weight_in    = weight_in_q;
    assign input_plugin = input_plugin_q;
    assign pixels_in    = pixels_in_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign out_last     = out_last_q;
    assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_xnor_tile_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_xnor_tile_driver
// Purpose  : Self-checking bench for xnor_tile_driver with a 1-cycle engine
//            model and a scoreboard of expected output words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xnor_tile_driver;

    localparam int K  = 16;
    localparam int OW = 8;
    localparam int CW = 16;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] c;
        logic       l;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [K-1:0]  cmd_weight;
    logic [CW-1:0] cmd_count;
    logic          pix_valid;
    logic          pix_ready;
    logic [K-1:0]  pix_data;
    logic          weight_wr;
    logic [K-1:0]  weight_in;
    logic          input_plugin;
    logic [K-1:0]  pixels_in;
    logic          ready_in;
    logic          result_in;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [3:0]    out_count;
    logic          out_last;
    logic          busy;
    logic          err;

    xnor_tile_driver #(
        .KERNEL_SIZE (K),
        .OUT_WIDTH   (OW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_weight   (cmd_weight),
        .cmd_count    (cmd_count),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .weight_wr    (weight_wr),
        .weight_in    (weight_in),
        .input_plugin (input_plugin),
        .pixels_in    (pixels_in),
        .ready_in     (ready_in),
        .result_in    (result_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_last     (out_last),
        .busy         (busy),
        .err          (err)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_wr = 0;
    int           n_plug = 0;
    int           n_overlap = 0;
    int           n_words = 0;
    int           ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit           gap_mode = 0;
    bit           inject = 0;
    exp_t         exp_q[$];
    logic [K-1:0] pix_q[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic act(input logic [K-1:0] p, input logic [K-1:0] w);
        logic [K-1:0] x;
        x = ~(p ^ w);
        return $countones(x) >= (K / 2);
    endfunction

    task automatic push_expected(input logic [K-1:0] w, input int first, input int n);
        logic [7:0] acc;
        int         f;
        acc = '0;
        f   = 0;
        for (int i = 0; i < n; i++) begin
            acc[f[2:0]] = act(pix_q[first + i], w);
            f++;
            if (f == OW) begin
                exp_q.push_back('{d: acc, c: 4'd8, l: (i == n - 1)});
                acc = '0;
                f   = 0;
            end
        end
        if (f > 0) begin
            exp_q.push_back('{d: acc, c: f[3:0], l: 1'b1});
        end
    endtask

    task automatic drive_ready();
        if (ready_mode == 2) begin
            out_ready = ($urandom_range(0, 1) == 1);
        end else begin
            out_ready = (ready_mode == 1);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        drive_ready();
    endtask

    // Engine model plus output monitor, all evaluated on the falling edge.
    initial begin
        logic [K-1:0] eng_w;
        logic         eng_pend;
        logic         eng_res;
        bit           held;
        exp_t         h;
        exp_t         e;
        eng_w    = '0;
        eng_pend = 1'b0;
        eng_res  = 1'b0;
        held     = 0;
        h        = '0;
        ready_in = 1'b0;
        result_in = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                ready_in  = 1'b0;
                result_in = 1'b0;
                eng_pend  = 1'b0;
                held      = 0;
            end else begin
                ready_in  = eng_pend | inject;
                result_in = eng_res;
                inject    = 0;
                if (weight_wr) begin
                    eng_w = weight_in;
                    n_wr++;
                end
                if (input_plugin) begin
                    n_plug++;
                end
                if (weight_wr && input_plugin) begin
                    n_overlap++;
                end
                eng_pend = input_plugin;
                eng_res  = act(pixels_in, eng_w);

                if (out_valid) begin
                    if (held) begin
                        check_eq("hold_stable", {out_data, out_count, out_last}, h);
                    end
                    if (out_ready) begin
                        n_words++;
                        held = 0;
                        check_eq("sb_has_entry", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check_eq("out_data", out_data, e.d);
                            check_eq("out_count", out_count, e.c);
                            check_eq("out_last", out_last, e.l);
                        end
                    end else begin
                        held = 1;
                        h    = '{d: out_data, c: out_count, l: out_last};
                    end
                end else begin
                    held = 0;
                end
            end
        end
    end

    task automatic send_cmd(input logic [K-1:0] w, input int n);
        bit acc;
        acc        = 0;
        cmd_valid  = 1'b1;
        cmd_weight = w;
        cmd_count  = CW'(n);
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clock);
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("cmd_accepted", acc, 1);
    endtask

    task automatic feed(input int first, input int n, input int budget, output int acc);
        bit hs;
        acc = 0;
        for (int cyc = 0; cyc < budget && acc < n; cyc++) begin
            pix_valid = !(gap_mode && ($urandom_range(0, 3) == 0));
            pix_data  = pix_q[first + acc];
            @(negedge clock);
            hs = pix_valid && pix_ready;
            tick();
            if (hs) begin
                acc++;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy && !out_valid) begin
                done = 1;
            end
            tick();
        end
        check_eq("drain_done", done, 1);
    endtask

    task automatic add_pixels(input int n, output int first);
        first = pix_q.size();
        for (int i = 0; i < n; i++) begin
            pix_q.push_back(K'($urandom));
        end
    endtask

    initial begin
        int           first;
        int           acc;
        int           wr0;
        int           plug0;
        int           words0;
        logic [K-1:0] w;
        int           counts[5];

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_weight = '0;
        cmd_count  = '0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_ctrl", {busy, pix_ready, weight_wr, input_plugin, out_valid, out_last, err}, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_data", {weight_in, pixels_in, out_data, out_count}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Three pixels, one partial word.
        first = pix_q.size();
        pix_q.push_back(16'h00FF);
        pix_q.push_back(16'h00FE);
        pix_q.push_back(16'h0FFF);
        push_expected(16'hFFFF, first, 3);
        send_cmd(16'hFFFF, 3);
        check_eq("busy_cmd_ready", cmd_ready, 0);
        feed(first, 3, 100, acc);
        check_eq("t1_accepted", acc, 3);
        wait_idle(100);

        // Exactly one full word, no trailing word.
        first = pix_q.size();
        for (int i = 0; i < 8; i++) begin
            pix_q.push_back((i % 2 == 0) ? 16'h0FFF : 16'h0000);
        end
        push_expected(16'hFFFF, first, 8);
        words0 = n_words;
        send_cmd(16'hFFFF, 8);
        feed(first, 8, 100, acc);
        check_eq("t2_accepted", acc, 8);
        wait_idle(100);
        check_eq("t2_word_count", n_words - words0, 1);

        // Zero-length command.
        wr0    = n_wr;
        plug0  = n_plug;
        words0 = n_words;
        send_cmd(16'h1234, 0);
        @(negedge clock);
        check_eq("cnt0_weight_wr", weight_wr, 1);
        check_eq("cnt0_weight_in", weight_in, 16'h1234);
        tick();
        @(negedge clock);
        check_eq("cnt0_cmd_ready", cmd_ready, 1);
        tick();
        repeat (5) tick();
        check_eq("cnt0_wr_pulses", n_wr - wr0, 1);
        check_eq("cnt0_plug_pulses", n_plug - plug0, 0);
        check_eq("cnt0_words", n_words - words0, 0);

        // Back-pressure: 20 pixels with the output stalled.
        ready_mode = 0;
        w = K'($urandom);
        add_pixels(20, first);
        push_expected(w, first, 20);
        send_cmd(w, 20);
        feed(first, 20, 60, acc);
        check_eq("stall_accepted", acc, 16);
        check_eq("stall_pix_ready", pix_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
        ready_mode = 1;
        drive_ready();
        feed(first + 16, 4, 100, acc);
        check_eq("stall_rest_accepted", acc, 4);
        wait_idle(200);

        // Back-to-back commands, random gaps and back-pressure.
        ready_mode = 2;
        gap_mode   = 1;
        counts     = '{1, 7, 9, 16, 13};
        for (int c = 0; c < 5; c++) begin
            w = K'($urandom);
            add_pixels(counts[c], first);
            push_expected(w, first, counts[c]);
            send_cmd(w, counts[c]);
            feed(first, counts[c], 400, acc);
            check_eq("b2b_accepted", acc, counts[c]);
        end
        wait_idle(400);
        gap_mode   = 0;
        ready_mode = 1;
        drive_ready();
        check_eq("wr_plug_overlap", n_overlap, 0);

        // Spurious engine result.
        check_eq("err_before", err, 0);
        inject = 1;
        tick();
        tick();
        check_eq("err_set", err, 1);
        repeat (5) tick();
        check_eq("err_sticky", err, 1);

        // Reset in the middle of a command.
        w = K'($urandom);
        add_pixels(20, first);
        send_cmd(w, 20);
        feed(first, 5, 50, acc);
        check_eq("rst_mid_accepted", acc, 5);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("rstmid_ctrl", {busy, pix_ready, weight_wr, input_plugin, out_valid, out_last, err}, 0);
        check_eq("rstmid_cmd_ready", cmd_ready, 1);
        check_eq("rstmid_data", {weight_in, pixels_in, out_data, out_count}, 0);
        tick();
        reset  = 1'b0;
        words0 = n_words;
        repeat (20) tick();
        check_eq("rstmid_no_word", n_words - words0, 0);
        check_eq("rstmid_out_valid", out_valid, 0);

        // Recovery after reset.
        w = K'($urandom);
        add_pixels(11, first);
        push_expected(w, first, 11);
        send_cmd(w, 11);
        feed(first, 11, 100, acc);
        check_eq("recover_accepted", acc, 11);
        wait_idle(200);
        check_eq("recover_err", err, 0);
        check_eq("final_overlap", n_overlap, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
